// File: rtl/seg7_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg7_pkg : shared 7-segment encoding constants                       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package seg7_pkg;

    typedef logic [6:0] seg7_t;

    // Segment order is {a,b,c,d,e,f,g}; entry 0 is the rightmost element.
    localparam logic [15:0][6:0] c_seg_table = {
        7'b1000111,  // F
        7'b1001111,  // E
        7'b0111101,  // d
        7'b1001110,  // C
        7'b0011111,  // b
        7'b1110111,  // A
        7'b1111011,  // 9
        7'b1111111,  // 8
        7'b1110000,  // 7
        7'b1011111,  // 6
        7'b1011011,  // 5
        7'b0110011,  // 4
        7'b1111001,  // 3
        7'b1101101,  // 2
        7'b0110000,  // 1
        7'b1111110   // 0
    };

    localparam seg7_t c_seg_blank = 7'b0000000;

endpackage : seg7_pkg
`default_nettype wire

// File: rtl/hex_to_seg7.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hex_to_seg7 : nibble to 7-segment decode, dp flags digits above 9    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg,
    output logic       o_dp
);

    assign o_seg = c_seg_table[i_nibble];
    assign o_dp  = (i_nibble > 4'd9);

endmodule : hex_to_seg7
`default_nettype wire

// File: rtl/seg_adder_scan.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg_adder_scan : registered adder shown on a multiplexed hex display |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module seg_adder_scan
    import seg7_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DIGITS      = 3,
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_LZ    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic              load,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] an,
    output logic              dp
);

    localparam int c_sum_w = WIDTH + 1;
    localparam int c_nib_w = 4 * DIGITS;
    localparam int c_cnt_w = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int c_idx_w = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(REFRESH_DIV - 1);
    localparam logic [c_idx_w-1:0] c_idx_max = c_idx_w'(DIGITS - 1);

    if (c_nib_w < c_sum_w) begin : g_digits_check
        $error("seg_adder_scan: DIGITS too small to show a WIDTH+1-bit sum");
    end
    if (REFRESH_DIV < 2) begin : g_refresh_check
        $error("seg_adder_scan: REFRESH_DIV must be at least 2");
    end

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [c_sum_w-1:0] r_sum;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_idx_w-1:0] r_idx;

    logic               w_tick;
    logic [c_nib_w-1:0] w_sel;
    logic [3:0]         w_nibble;
    logic               w_blank;
    seg7_t              w_seg;
    logic               w_dp;

    assign w_tick   = (r_cnt == c_cnt_max);
    // After shifting the selected digit down, the remaining value being zero
    // means this digit and everything above it are leading zeros.
    assign w_sel    = c_nib_w'(r_sum) >> (4 * r_idx);
    assign w_nibble = w_sel[3:0];
    assign w_blank  = (BLANK_LZ != 0) && (r_idx != '0) && (w_sel == '0);

    hex_to_seg7 u_hex_to_seg7 (
        .i_nibble (w_nibble),
        .o_seg    (w_seg),
        .o_dp     (w_dp)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_sum <= '0;
            r_cnt <= '0;
            r_idx <= '0;
        end else begin
            if (load) begin
                r_a <= a;
                r_b <= b;
            end
            r_sum <= c_sum_w'(r_a) + c_sum_w'(r_b);
            r_cnt <= w_tick ? '0 : r_cnt + c_cnt_w'(1);
            if (w_tick) begin
                r_idx <= (r_idx == c_idx_max) ? '0 : r_idx + c_idx_w'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg <= c_seg_blank;
            an  <= '0;
            dp  <= 1'b0;
        end else begin
            seg <= w_blank ? c_seg_blank : w_seg;
            an  <= DIGITS'(1) << r_idx;
            dp  <= w_blank ? 1'b0 : w_dp;
        end
    end

endmodule : seg_adder_scan
`default_nettype wire

// File: doc/seg_adder_scan.md
SEG_ADDER_SCAN -- requirements
Module: seg_adder_scan

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits, range 1..32.
REQ-002 Parameter DIGITS, default 3: number of multiplexed 7-segment digits; SHALL satisfy DIGITS >= ceil((WIDTH+1)/4), else elaboration SHALL fail.
REQ-003 Parameter REFRESH_DIV, default 50000: clock cycles per digit slot, minimum 2.
REQ-004 Parameter BLANK_LZ, default 1: 1 = blank leading zero digits, 0 = show all digits.
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 a  input  WIDTH  operand A, unsigned.
REQ-008 b  input  WIDTH  operand B, unsigned.
REQ-009 load  input  1  capture strobe for a and b.
REQ-010 seg  output  7  segments {a,b,c,d,e,f,g}, active-high, registered.
REQ-011 an  output  DIGITS  one-hot digit enable, active-high, registered; bit 0 = least significant digit.
REQ-012 dp  output  1  decimal point of the active digit, active-high, registered.

Function
REQ-013 When load=1 at a rising edge, a and b SHALL be captured into operand registers; load held high SHALL capture every cycle.
REQ-014 The cycle after capture, sum_q SHALL hold a_q + b_q as an unsigned WIDTH+1-bit value, carry included.
REQ-015 sum_q SHALL be zero-extended to 4*DIGITS bits; nibble i SHALL drive digit i.
REQ-016 A refresh counter SHALL count 0..REFRESH_DIV-1 and wrap to 0; the cycle it holds REFRESH_DIV-1 is a tick.
REQ-017 On each tick, the digit index SHALL advance by 1, wrapping from DIGITS-1 to 0.
REQ-018 Every cycle, an SHALL be registered as one-hot of the digit index, and seg as the decode of the selected nibble.
REQ-019 Hex decode SHALL be: 0=1111110 1=0110000 2=1101101 3=1111001 4=0110011 5=1011011 6=1011111 7=1110000 8=1111111 9=1111011 A=1110111 b=0011111 C=1001110 d=0111101 E=1001111 F=1000111.
REQ-020 dp SHALL be 1 when the selected nibble is greater than 9, flagging a non-decimal digit, else 0.
REQ-021 With BLANK_LZ=1, digit i>0 SHALL output seg=0000000 and dp=0 when nibbles i..DIGITS-1 are all zero; digit 0 SHALL never blank; an is unaffected by blanking.
REQ-022 Latency: load sampled at edge k SHALL update sum_q at edge k+1 and seg/dp for the active digit at edge k+2.
REQ-023 A load coinciding with a tick SHALL perform both actions; the new digit index SHALL be shown with the old sum for one cycle, then the new sum.
REQ-024 There SHALL be no handshake back-pressure; the block always accepts load.

Reset
REQ-025 While rst=1: operand registers, sum_q, refresh counter and digit index SHALL be 0, and seg=0000000, an=0, dp=0.
REQ-026 On the first edge after rst deasserts, an SHALL become ...001 and seg SHALL become 1111110.
REQ-027 Reset asserted mid-scan or mid-load SHALL take effect immediately and discard any captured operands.

Structure
REQ-028 The 16-entry segment table (REQ-019) and the blank pattern constant SHALL live in shared package seg7_pkg.
REQ-029 A combinational sub-module hex_to_seg7 (4-bit nibble in, 7-bit seg and dp out) SHALL perform REQ-019/REQ-020; seg_adder_scan SHALL instantiate it once on the muxed nibble.

Verification (WIDTH=8, DIGITS=3, REFRESH_DIV=4)
REQ-030 Assert rst mid-run -> seg=0000000, an=000, dp=0 immediately; release -> an=001, seg=1111110 after one edge.
REQ-031 a=0x3C, b=0x05, load for 1 cycle -> sum 0x041; digit0 seg 0110000, digit1 0110011, digit2 0000000 (BLANK_LZ=1) or 1111110 (BLANK_LZ=0); dp=0 throughout.
REQ-032 a=0xFF, b=0xFF -> sum 0x1FE; digit0 1001111 dp=1, digit1 1000111 dp=1, digit2 0110000 dp=0.
REQ-033 No load, free-run -> an sequence 001,010,100,001, each held 4 cycles, with no glitch at the wrap.
REQ-034 Load a=0x01, b=0x01 on a tick cycle -> an advances that edge, seg shows old sum one cycle, then 1101101 on digit0 per REQ-022/REQ-023.
